// File: rtl/fpu_issue_ctrl.sv
// Request-side issue controller for the FPU.
// Accepts one request at a time, pulses the one-hot opcode, waits for the
// FPU result (with a watchdog) and returns the result with its tag.
// Every output is driven straight from a register.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TAGW    = 5
) (
    input  logic            sys_clk,
    input  logic            rstn,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [31:0]     req_x1,
    input  logic [31:0]     req_x2,
    input  logic [TAGW-1:0] req_tag,

    output logic [7:0]      fpu_opcode,
    output logic [31:0]     fpu_x1,
    output logic [31:0]     fpu_x2,
    input  logic [31:0]     fpu_y,
    input  logic            fpu_ovf,
    input  logic            fpu_out_valid,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_y,
    output logic            rsp_ovf,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_timeout,

    output logic            busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    // In WAIT the counter holds (WAIT cycle index - 1); this value marks the last WAIT cycle.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TAGW-1:0]   tag_q, tag_d;

    logic              req_ready_q, req_ready_d;
    logic [7:0]        fpu_opcode_q, fpu_opcode_d;
    logic [31:0]       fpu_x1_q, fpu_x1_d;
    logic [31:0]       fpu_x2_q, fpu_x2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_y_q, rsp_y_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic [TAGW-1:0]   rsp_tag_q, rsp_tag_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              busy_q, busy_d;

    logic              accept;

    // req_ready_q is low in the first cycle after reset, so no accept can happen there.
    assign accept = req_valid && req_ready_q;

    // Next-state, watchdog and output-register computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        fpu_opcode_d  = 8'h00;
        fpu_x1_d      = fpu_x1_q;
        fpu_x2_d      = fpu_x2_q;
        rsp_y_d       = rsp_y_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    // Opcode is registered here so the pulse lands in the ISSUE cycle.
                    fpu_opcode_d = 8'b1 << req_op;
                    fpu_x1_d     = req_x1;
                    fpu_x2_d     = req_x2;
                    tag_d        = req_tag;
                    state_d      = StIssue;
                end
            end

            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // A result in the last WAIT cycle still wins over the watchdog.
                if (fpu_out_valid) begin
                    rsp_y_d       = fpu_y;
                    rsp_ovf_d     = fpu_ovf;
                    rsp_timeout_d = 1'b0;
                    rsp_tag_d     = tag_q;
                    state_d       = StResp;
                end else if (cnt_q == CntLast) begin
                    rsp_y_d       = 32'h0000_0000;
                    rsp_ovf_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_tag_d     = tag_q;
                    state_d       = StResp;
                end
            end

            StResp: begin
                // rsp_valid_q is always high in RESP, so rsp_ready alone completes it.
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        busy_d      = (state_d != StIdle);
    end

    // FSM state, watchdog counter and captured tag.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    // Registered outputs toward the FPU, the requester and the consumer.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            req_ready_q   <= 1'b0;
            fpu_opcode_q  <= 8'h00;
            fpu_x1_q      <= 32'h0000_0000;
            fpu_x2_q      <= 32'h0000_0000;
            rsp_valid_q   <= 1'b0;
            rsp_y_q       <= 32'h0000_0000;
            rsp_ovf_q     <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            req_ready_q   <= req_ready_d;
            fpu_opcode_q  <= fpu_opcode_d;
            fpu_x1_q      <= fpu_x1_d;
            fpu_x2_q      <= fpu_x2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_y_q       <= rsp_y_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign fpu_opcode  = fpu_opcode_q;
    assign fpu_x1      = fpu_x1_q;
    assign fpu_x2      = fpu_x2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed cases plus randomized
// transactions, each compared against a transaction-level expectation.
module tb_fpu_issue_ctrl;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned TAGW    = 5;

    logic            sys_clk = 1'b0;
    logic            rstn;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [31:0]     req_x1;
    logic [31:0]     req_x2;
    logic [TAGW-1:0] req_tag;
    logic [7:0]      fpu_opcode;
    logic [31:0]     fpu_x1;
    logic [31:0]     fpu_x2;
    logic [31:0]     fpu_y;
    logic            fpu_ovf;
    logic            fpu_out_valid;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_y;
    logic            rsp_ovf;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_timeout;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    fpu_issue_ctrl #(
        .TIMEOUT (TIMEOUT),
        .TAGW    (TAGW)
    ) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_x1        (req_x1),
        .req_x2        (req_x2),
        .req_tag       (req_tag),
        .fpu_opcode    (fpu_opcode),
        .fpu_x1        (fpu_x1),
        .fpu_x2        (fpu_x2),
        .fpu_y         (fpu_y),
        .fpu_ovf       (fpu_ovf),
        .fpu_out_valid (fpu_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_y         (rsp_y),
        .rsp_ovf       (rsp_ovf),
        .rsp_tag       (rsp_tag),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check_eq({where, " req_ready"},   64'(req_ready),   64'(0));
        check_eq({where, " fpu_opcode"},  64'(fpu_opcode),  64'(0));
        check_eq({where, " fpu_x1"},      64'(fpu_x1),      64'(0));
        check_eq({where, " fpu_x2"},      64'(fpu_x2),      64'(0));
        check_eq({where, " rsp_valid"},   64'(rsp_valid),   64'(0));
        check_eq({where, " rsp_y"},       64'(rsp_y),       64'(0));
        check_eq({where, " rsp_ovf"},     64'(rsp_ovf),     64'(0));
        check_eq({where, " rsp_tag"},     64'(rsp_tag),     64'(0));
        check_eq({where, " rsp_timeout"}, 64'(rsp_timeout), 64'(0));
        check_eq({where, " busy"},        64'(busy),        64'(0));
    endtask

    // One request end to end. lat: WAIT cycle in which the FPU answers (0 = never).
    // spur: pulse fpu_out_valid during the ISSUE cycle. bp: cycles of rsp_ready=0.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [TAGW-1:0] tag, input int lat, input logic [31:0] y,
                           input logic ovf, input int bp, input bit spur);
        bit          exp_to;
        int          exp_k;
        logic [7:0]  exp_op;
        logic [31:0] exp_y;
        logic        exp_ovf;
        int          k;
        bit          seen;

        // Reference: result inside the TIMEOUT-cycle window wins, otherwise watchdog.
        exp_to  = !(lat >= 1 && lat <= int'(TIMEOUT));
        exp_k   = (exp_to ? int'(TIMEOUT) : lat) + 1;
        exp_op  = 8'd1 << op;
        exp_y   = exp_to ? 32'd0 : y;
        exp_ovf = exp_to ? 1'b0 : ovf;

        @(posedge sys_clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_x1    = x1;
        req_x2    = x2;
        req_tag   = tag;
        @(negedge sys_clk);
        check_eq("idle req_ready", 64'(req_ready), 64'(1));
        check_eq("idle busy", 64'(busy), 64'(0));

        // Edge E accepts; cycle C is the ISSUE cycle.
        @(posedge sys_clk); #1;
        req_valid     = 1'b0;
        req_op        = 3'($urandom_range(0, 7));
        req_x1        = $urandom;
        req_x2        = $urandom;
        req_tag       = TAGW'($urandom);
        fpu_out_valid = spur;
        fpu_y         = $urandom;
        fpu_ovf       = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        check_eq("issue opcode", 64'(fpu_opcode), 64'(exp_op));
        check_eq("issue x1", 64'(fpu_x1), 64'(x1));
        check_eq("issue x2", 64'(fpu_x2), 64'(x2));
        check_eq("issue req_ready", 64'(req_ready), 64'(0));
        check_eq("issue busy", 64'(busy), 64'(1));

        seen = 1'b0;
        k    = 0;
        while (!seen && k < int'(TIMEOUT) + 8) begin
            @(posedge sys_clk); #1;
            k++;
            fpu_out_valid = (k == lat);
            fpu_y         = (k == lat) ? y : $urandom;
            fpu_ovf       = (k == lat) ? ovf : 1'($urandom_range(0, 1));
            @(negedge sys_clk);
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                check_eq("wait opcode", 64'(fpu_opcode), 64'(0));
                check_eq("wait busy", 64'(busy), 64'(1));
                check_eq("wait req_ready", 64'(req_ready), 64'(0));
            end
        end
        check_eq("rsp latency", 64'(k), 64'(exp_k));

        for (int i = 0; i <= bp; i++) begin
            if (i > 0) begin
                // Stray FPU pulses while the response waits must not disturb it.
                @(posedge sys_clk); #1;
                fpu_out_valid = 1'($urandom_range(0, 1));
                fpu_y         = $urandom;
                fpu_ovf       = 1'($urandom_range(0, 1));
                @(negedge sys_clk);
            end
            check_eq("rsp valid", 64'(rsp_valid), 64'(1));
            check_eq("rsp y", 64'(rsp_y), 64'(exp_y));
            check_eq("rsp ovf", 64'(rsp_ovf), 64'(exp_ovf));
            check_eq("rsp tag", 64'(rsp_tag), 64'(tag));
            check_eq("rsp timeout", 64'(rsp_timeout), 64'(exp_to));
            check_eq("rsp busy", 64'(busy), 64'(1));
            check_eq("rsp req_ready", 64'(req_ready), 64'(0));
        end

        @(posedge sys_clk); #1;
        fpu_out_valid = 1'b0;
        rsp_ready     = 1'b1;
        @(negedge sys_clk);
        check_eq("hs rsp_valid", 64'(rsp_valid), 64'(1));
        @(posedge sys_clk); #1;
        rsp_ready = 1'b0;
        @(negedge sys_clk);
        check_eq("post rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("post busy", 64'(busy), 64'(0));
        check_eq("post req_ready", 64'(req_ready), 64'(1));
        check_eq("post x1 held", 64'(fpu_x1), 64'(x1));
        check_eq("post x2 held", 64'(fpu_x2), 64'(x2));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got %0t expected finish earlier", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int          lat;
        int          r;
        logic [31:0] y;

        rstn          = 1'b0;
        req_valid     = 1'b0;
        req_op        = 3'd0;
        req_x1        = 32'd0;
        req_x2        = 32'd0;
        req_tag       = '0;
        fpu_y         = 32'd0;
        fpu_ovf       = 1'b0;
        fpu_out_valid = 1'b0;
        rsp_ready     = 1'b0;

        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset");
        @(posedge sys_clk); #1;
        rstn = 1'b1;
        @(negedge sys_clk);
        check_eq("release req_ready early", 64'(req_ready), 64'(0));
        @(negedge sys_clk);
        check_eq("release req_ready", 64'(req_ready), 64'(1));

        // Spurious FPU pulse in IDLE.
        @(posedge sys_clk); #1;
        fpu_out_valid = 1'b1;
        fpu_y         = 32'hdeadbeef;
        @(posedge sys_clk); #1;
        fpu_out_valid = 1'b0;
        @(negedge sys_clk);
        check_eq("idle spur rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("idle spur busy", 64'(busy), 64'(0));
        check_eq("idle spur rsp_y", 64'(rsp_y), 64'(0));

        // Normal fadd.
        run_txn(3'd0, 32'h44fa21b3, 32'h44fa40f8, 5'd3, 3, 32'h457a3156, 1'b0, 0, 1'b0);
        // Backpressure.
        run_txn(3'd7, 32'h3f800000, 32'h40000000, 5'd17, 2, 32'h40400000, 1'b0, 5, 1'b0);
        // Timeout.
        run_txn(3'd2, 32'h12345678, 32'h9abcdef0, 5'd9, 0, 32'h0, 1'b0, 1, 1'b0);
        // Last-cycle tie.
        run_txn(3'd4, 32'h3f000000, 32'h3f000000, 5'd30, int'(TIMEOUT), 32'h3fd61587, 1'b1,
                0, 1'b0);
        // Spurious pulse in the ISSUE cycle.
        run_txn(3'd5, 32'h11111111, 32'h22222222, 5'd1, 2, 32'h33333333, 1'b1, 0, 1'b1);

        // Reset during WAIT.
        @(posedge sys_clk); #1;
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_x1    = 32'hcafef00d;
        req_x2    = 32'h0badf00d;
        req_tag   = 5'd21;
        @(negedge sys_clk);
        check_eq("rw req_ready", 64'(req_ready), 64'(1));
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        check_eq("rw busy", 64'(busy), 64'(1));
        @(posedge sys_clk); #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midwait");
        repeat (3) @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        @(negedge sys_clk);
        check_eq("rw release req_ready", 64'(req_ready), 64'(0));
        @(posedge sys_clk); #1;
        fpu_out_valid = 1'b1;
        fpu_y         = 32'h55aa55aa;
        fpu_ovf       = 1'b1;
        @(negedge sys_clk);
        check_eq("rw late req_ready", 64'(req_ready), 64'(1));
        check_eq("rw late rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge sys_clk); #1;
        fpu_out_valid = 1'b0;
        @(negedge sys_clk);
        check_eq("rw after rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rw after busy", 64'(busy), 64'(0));
        check_eq("rw after rsp_y", 64'(rsp_y), 64'(0));
        run_txn(3'd6, 32'h40490fdb, 32'h402df854, 5'd12, 4, 32'h40f8a3d7, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      lat = 0;
            else if (r == 1) lat = int'(TIMEOUT);
            else if (r == 2) lat = int'(TIMEOUT) + 1 + int'($urandom_range(0, 4));
            else             lat = int'($urandom_range(1, 8));
            y = $urandom;
            run_txn(3'($urandom_range(0, 7)), $urandom, $urandom, TAGW'($urandom), lat, y,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
